rf_wb_arbiter: RTL

Shares the register file's single write port between two writeback sources: src0 (ALU) and src1 (load/store unit). Uses round-robin arbitration and registers the winning write onto the register file write port (we/waddr/wbdata). Also keeps a per-register busy scoreboard so issue logic can stall on reads of registers with a write still pending. Sits between the execute/memory stages and the register file.

---
 rtl/rf_wb_arbiter.sv | 131 +++++++++++++
 1 files changed

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter
// Two writeback sources share the register file's single write port.
// src0 is the ALU and src1 is the load/store unit. A round-robin grant
// picks one source per cycle, and the winning write is registered onto
// we/waddr/wbdata. A busy scoreboard marks registers that still have a
// write pending, so issue logic can stall reads of those registers.
//
// Ports
//   clk, reset           : clock; asynchronous active-high reset
//   hold                 : when 1, no source is granted this cycle
//   src{0,1}_valid/addr/data : write requests
//   src{0,1}_ready       : combinational grant, never asserted without valid
//   we, waddr, wbdata    : registered register file write port
//   sb_set, sb_addr      : issue stage marks sb_addr busy
//   rs1, rs2             : read addresses being issued
//   rs1_busy, rs2_busy   : combinational lookup of the busy vector
//   sb_err               : sticky flag, sb_set hit an already-busy register
//
// Handshake: a source write is transferred on a rising edge where
// srcN_valid && srcN_ready. Ready is a pure function of this cycle's
// valids, hold and the round-robin pointer. There is no backpressure
// on the register file side.
module rf_wb_arbiter #(
  parameter int ADDR_W      = 5,
  parameter int DATA_W      = 32,
  parameter bit ZERO_REG_EN = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hold,
  input  logic              src0_valid,
  input  logic [ADDR_W-1:0] src0_addr,
  input  logic [DATA_W-1:0] src0_data,
  output logic              src0_ready,
  input  logic              src1_valid,
  input  logic [ADDR_W-1:0] src1_addr,
  input  logic [DATA_W-1:0] src1_data,
  output logic              src1_ready,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [DATA_W-1:0] wbdata,
  input  logic              sb_set,
  input  logic [ADDR_W-1:0] sb_addr,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  output logic              rs1_busy,
  output logic              rs2_busy,
  output logic              sb_err
);

  localparam int NREGS = 1 << ADDR_W;

  logic              rr_q, rr_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wbdata_q, wbdata_d;
  logic [NREGS-1:0]  busy_q, busy_d;
  logic              err_q, err_d;

  logic              gnt0, gnt1, any_gnt;
  logic [ADDR_W-1:0] gnt_addr;
  logic [DATA_W-1:0] gnt_data;
  logic              set_ok;
  logic              clr_hit;

  // Round-robin only matters on contention; a lone requester always wins.
  always_comb begin
    gnt0 = !hold && src0_valid && (!src1_valid || (rr_q == 1'b0));
    gnt1 = !hold && src1_valid && (!src0_valid || (rr_q == 1'b1));
    any_gnt  = gnt0 || gnt1;
    gnt_addr = gnt1 ? src1_addr : src0_addr;
    gnt_data = gnt1 ? src1_data : src0_data;
  end

  assign src0_ready = gnt0;
  assign src1_ready = gnt1;

  always_comb begin
    rr_d     = rr_q;
    we_d     = 1'b0;
    waddr_d  = waddr_q;
    wbdata_d = wbdata_q;
    if (any_gnt) begin
      // Pointer moves to the source that lost (or did not compete).
      rr_d     = gnt0 ? 1'b1 : 1'b0;
      waddr_d  = gnt_addr;
      wbdata_d = gnt_data;
      // A write to the hardwired zero register is consumed but never issued.
      we_d     = !(ZERO_REG_EN && (gnt_addr == '0));
    end
  end

  // Scoreboard: the clear is applied first so a same-edge set wins.
  always_comb begin
    set_ok  = sb_set && !(ZERO_REG_EN && (sb_addr == '0));
    clr_hit = we_q && (waddr_q == sb_addr);
    busy_d  = busy_q;
    err_d   = err_q;
    if (we_q) busy_d[waddr_q] = 1'b0;
    if (set_ok) begin
      busy_d[sb_addr] = 1'b1;
      if (busy_q[sb_addr] && !clr_hit) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_q     <= 1'b0;
      we_q     <= 1'b0;
      waddr_q  <= '0;
      wbdata_q <= '0;
      busy_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      rr_q     <= rr_d;
      we_q     <= we_d;
      waddr_q  <= waddr_d;
      wbdata_q <= wbdata_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
    end
  end

  assign we       = we_q;
  assign waddr    = waddr_q;
  assign wbdata   = wbdata_q;
  assign sb_err   = err_q;
  assign rs1_busy = busy_q[rs1];
  assign rs2_busy = busy_q[rs2];

endmodule
